// File: rtl/gate_finder_pkg.sv
// Gate finder shared types: FSM states, gate codes and truth-table patterns.
// Continuous rescanning is enabled by defining GATE_FINDER_CONTINUOUS_EN.
package gate_finder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    SETTLE,
    DONE
  } state_t;

  localparam logic [2:0] GATE_UNKNOWN = 3'd0;
  localparam logic [2:0] GATE_AND     = 3'd1;
  localparam logic [2:0] GATE_OR      = 3'd2;
  localparam logic [2:0] GATE_NAND    = 3'd3;
  localparam logic [2:0] GATE_NOR     = 3'd4;
  localparam logic [2:0] GATE_XOR     = 3'd5;
  localparam logic [2:0] GATE_XNOR    = 3'd6;
  localparam logic [2:0] GATE_STUCK   = 3'd7;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;
  localparam logic [3:0] TT_LOW  = 4'b0000;
  localparam logic [3:0] TT_HIGH = 4'b1111;

  localparam logic [1:0] PAT_FIRST = 2'd0;
  localparam logic [1:0] PAT_LAST  = 2'd3;

  function automatic logic [2:0] classify(
    input logic [3:0] tt
  );
    logic [2:0] g;
    case (tt)
      TT_AND:  g = GATE_AND;
      TT_OR:   g = GATE_OR;
      TT_NAND: g = GATE_NAND;
      TT_NOR:  g = GATE_NOR;
      TT_XOR:  g = GATE_XOR;
      TT_XNOR: g = GATE_XNOR;
      TT_LOW,
      TT_HIGH: g = GATE_STUCK;
      default: g = GATE_UNKNOWN;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/gate_finder_sync.sv
// Multi-flop synchronizer for the asynchronous GUT output pin.
// Continuous rescanning is enabled by defining GATE_FINDER_CONTINUOUS_EN.
module gate_finder_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/gate_finder_ctrl.sv
// Steps 2-input patterns onto the GUT and classifies the sampled gate.
// Continuous rescanning is enabled by defining GATE_FINDER_CONTINUOUS_EN.
module gate_finder_ctrl
  import gate_finder_pkg::*;
#(
  parameter int SETTLE_TICKS = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       slow_clk,
  input  logic       start,
  input  logic       dut_out,
  output logic       dut_a,
  output logic       dut_b,
  output logic       busy,
  output logic       valid,
  output logic [3:0] truth_table,
  output logic [2:0] gate_code
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_TICKS);

  state_t     state;
  logic       slow_q;
  logic       tick;
  logic       sample;
  logic [1:0] p;
  logic [3:0] cnt;

  assign tick = slow_clk & ~slow_q;

  gate_finder_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (dut_out),
    .q  (sample)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      slow_q      <= 1'b0;
      p           <= PAT_FIRST;
      cnt         <= '0;
      dut_a       <= 1'b0;
      dut_b       <= 1'b0;
      busy        <= 1'b0;
      valid       <= 1'b0;
      truth_table <= '0;
      gate_code   <= GATE_UNKNOWN;
    end else begin
      slow_q <= slow_clk;
      case (state)
        IDLE: begin
          // a tick coinciding with start is deliberately not used for ARM
          if (start) begin
            state       <= ARM;
            busy        <= 1'b1;
            valid       <= 1'b0;
            truth_table <= '0;
            p           <= PAT_FIRST;
          end
        end
        ARM: begin
          if (tick) begin
            {dut_a, dut_b} <= p;
            cnt            <= '0;
            state          <= SETTLE;
          end
        end
        SETTLE: begin
          if (tick) begin
            if (cnt + 4'd1 == SETTLE_LAST) begin
              truth_table[p] <= sample;
              cnt            <= '0;
              if (p == PAT_LAST) begin
                state <= DONE;
              end else begin
                p              <= p + 2'd1;
                {dut_a, dut_b} <= p + 2'd1;
              end
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        DONE: begin
          gate_code <= classify(truth_table);
          valid     <= 1'b1;
          dut_a     <= 1'b0;
          dut_b     <= 1'b0;
`ifdef GATE_FINDER_CONTINUOUS_EN
          state     <= ARM;
          p         <= PAT_FIRST;
`else
          state     <= IDLE;
          busy      <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/gate_finder_ctrl.md
Name: gate_finder_ctrl

Overview:
- Consumes the slow toggling clock from the 1 Hz-class clock divider in the gate finder.
- On each rising edge of that slow clock, it steps a 2-input stimulus pattern onto the gate under test (GUT).
- It samples the GUT output through a synchronizer, builds a 4-entry truth table and classifies the gate type.
- Results go to the board LED/display logic downstream.

Parameters:
- SETTLE_TICKS, 1: slow-clock rising edges between applying a pattern and sampling it; legal range 1..15.
- SYNC_STAGES, 2: flops in the dut_out synchronizer; legal range 2..3.

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  reset, asynchronous, active-high
- slow_clk  in  1  divider output, registered in the clk domain; only rising edges are used
- start  in  1  single-cycle request to begin a scan; ignored while busy
- dut_out  in  1  GUT output pin, asynchronous
- dut_a  out  1  stimulus input A of the GUT
- dut_b  out  1  stimulus input B of the GUT
- busy  out  1  high from start acceptance until results are valid
- valid  out  1  high while truth_table/gate_code hold a completed scan
- truth_table  out  4  bit i = sampled output for pattern {a,b}=i
- gate_code  out  3  classification result (see Behaviour)

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, edge-detect register 0, synchronizer flops 0, pattern index 0.
  - rst mid-scan aborts immediately to this state; no partial result is kept.
- Edge detect: tick = slow_clk & ~slow_clk_q, one clk cycle wide. The FSM advances only on tick.
- dut_out passes through SYNC_STAGES flops; the sampled value is the last stage.
- FSM states: IDLE, ARM, SETTLE, DONE.
  - IDLE: on start, go to ARM. busy=1, valid=0, truth_table is cleared, pattern index p=0.
  - ARM: on tick, drive {dut_a,dut_b}=p (registered, visible the cycle after tick), clear settle counter, go to SETTLE.
  - SETTLE: each tick increments the counter. On the tick where counter reaches SETTLE_TICKS:
    - write sampled dut_out into truth_table[p].
    - if p<3: p<=p+1 and drive the new pattern in the same cycle; stay in SETTLE with the counter cleared.
    - if p==3: go to DONE.
  - DONE (one cycle): register gate_code, valid<=1, busy<=0, dut_a/dut_b<=0, return to IDLE.
- valid stays high until the next accepted start.
- Total latency from start to valid: 1 + 4*SETTLE_TICKS tick edges, plus 1 clk cycle.
- start and tick in the same cycle: start is accepted. That tick is NOT used for ARM; ARM waits for the next tick.
- start while busy is ignored. A start held for multiple cycles is accepted once, on entry to IDLE.
- Classification, combinational from the truth table (written as bit3..bit0), registered in DONE:
  - 1000 → 1 AND
  - 1110 → 2 OR
  - 0111 → 3 NAND
  - 0001 → 4 NOR
  - 0110 → 5 XOR
  - 1001 → 6 XNOR
  - 0000 or 1111 → 7 STUCK (no gate / shorted)
  - anything else → 0 UNKNOWN

Optional Feature:
- Macro: GATE_FINDER_CONTINUOUS_EN.
- Defined: DONE returns to ARM instead of IDLE with p=0, so scans repeat indefinitely without start.
  - valid stays high; truth_table/gate_code update at each DONE.
  - busy stays high after the first start.
  - truth_table is not cleared between scans; each entry is overwritten as it is sampled.
- Undefined: single-shot behaviour as above; the start port still exists.

Decomposition:
- Package gate_finder_pkg holds:
  - the FSM state enum (IDLE, ARM, SETTLE, DONE);
  - the gate_code constants (GATE_UNKNOWN=0 … GATE_STUCK=7);
  - the truth-table pattern constants.
- One sub-module, gate_finder_sync: a parameterised SYNC_STAGES bit synchronizer with async reset.

Test Plan:
- SETTLE_TICKS=1, GUT modelled as AND, slow_clk toggling every 4 clk, pulse start → truth_table=4'b1000, gate_code=1, valid=1 after 5 tick edges; dut_a/dut_b sequence 00,01,10,11 then 00.
- GUT=XOR, SETTLE_TICKS=3 → truth_table=4'b0110, gate_code=5 after 13 tick edges; each pattern held exactly 3 ticks.
- dut_out tied 0 → gate_code=7. Truth table 4'b0100 → gate_code=0.
- Assert rst after the second pattern is sampled → all outputs 0 next cycle. A new start completes a normal scan.
- start coincident with tick → ARM waits for the following tick. A second start mid-scan → no effect on pattern sequence or latency.
- With GATE_FINDER_CONTINUOUS_EN: GUT changed from OR to NOR mid-run → gate_code goes 2 then 4 within one scan period, with no start after the first.
